tank_spawn_ctrl: RTL and testbench



---
 rtl/tank_spawn_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_tank_spawn_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/tank_spawn_ctrl.sv
// tank_spawn_ctrl: enemy-tank spawn manager for NUM_TANKS slots.
// Each slot runs WAIT -> READY -> REQ -> ALIVE -> WAIT. A round-robin arbiter
// grants one READY slot per game tick while the number of REQ/ALIVE slots is
// below MAX_ALIVE. tank_en, alive_cnt, kill_cnt and spawn_pulse are registered.
// Optional build macro SPAWN_WAVE_EN: the respawn delay shrinks by one tick per
// 8 kills (max(1, RESPAWN_TICKS - kill_cnt[7:3])). Without it the respawn delay
// is always RESPAWN_TICKS.

// Per-slot state machine and tick timer.
module tank_spawn_slot #(
    parameter int INIT_DELAY = 2,
    parameter int ACK_TICKS  = 3,
    parameter int TICK_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_i,
    input  logic              game_run_i,
    input  logic              tank_state_i,
    input  logic              grant_i,
    input  logic [TICK_W-1:0] resp_dly_i,
    output logic              ready_o,
    output logic              occ_o,
    output logic              alive_nxt_o,
    output logic              en_nxt_o,
    output logic              death_o
);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_READY = 2'd1,
        ST_REQ   = 2'd2,
        ST_ALIVE = 2'd3
    } slot_st_e;

    localparam logic [TICK_W-1:0] T_INIT = TICK_W'(INIT_DELAY);
    localparam logic [TICK_W-1:0] T_ACK  = TICK_W'(ACK_TICKS);
    localparam logic [TICK_W-1:0] T_ONE  = TICK_W'(1);

    slot_st_e          st_q, st_d;
    logic [TICK_W-1:0] tmr_q, tmr_d;

    // State and timer registers; reset parks the slot in WAIT with the initial delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q  <= ST_WAIT;
            tmr_q <= T_INIT;
        end else begin
            st_q  <= st_d;
            tmr_q <= tmr_d;
        end
    end

    // Next-state logic; a pause overrides everything and restarts the initial delay.
    always_comb begin
        st_d    = st_q;
        tmr_d   = tmr_q;
        death_o = 1'b0;
        if (!game_run_i) begin
            st_d  = ST_WAIT;
            tmr_d = T_INIT;
        end else begin
            case (st_q)
                ST_WAIT: begin
                    // The tick that brings the timer to zero also makes the slot READY.
                    if (tick_i) begin
                        if (tmr_q <= T_ONE) begin
                            st_d  = ST_READY;
                            tmr_d = '0;
                        end else begin
                            tmr_d = tmr_q - T_ONE;
                        end
                    end
                end
                ST_READY: begin
                    // tank_state is deliberately ignored until the slot is granted.
                    if (grant_i) begin
                        st_d  = ST_REQ;
                        tmr_d = T_ACK;
                    end
                end
                ST_REQ: begin
                    if (tank_state_i) begin
                        st_d = ST_ALIVE;
                    end else if (tick_i) begin
                        // No acknowledge in time: back off for a single tick and retry.
                        if (tmr_q <= T_ONE) begin
                            st_d  = ST_WAIT;
                            tmr_d = T_ONE;
                        end else begin
                            tmr_d = tmr_q - T_ONE;
                        end
                    end
                end
                ST_ALIVE: begin
                    if (!tank_state_i) begin
                        st_d    = ST_WAIT;
                        tmr_d   = resp_dly_i;
                        death_o = 1'b1;
                    end
                end
                default: begin
                    st_d  = ST_WAIT;
                    tmr_d = T_INIT;
                end
            endcase
        end
    end

    assign ready_o     = (st_q == ST_READY);
    assign occ_o       = (st_q == ST_REQ) || (st_q == ST_ALIVE);
    assign alive_nxt_o = (st_d == ST_ALIVE);
    assign en_nxt_o    = (st_d == ST_REQ) || (st_d == ST_ALIVE);

endmodule

// Top level: slot array, occupancy cap, round-robin grant and counters.
module tank_spawn_ctrl #(
    parameter int NUM_TANKS     = 4,
    parameter int MAX_ALIVE     = 4,
    parameter int INIT_DELAY    = 2,
    parameter int RESPAWN_TICKS = 8,
    parameter int ACK_TICKS     = 3,
    parameter int TICK_W        = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               tick,
    input  logic                               game_run,
    input  logic [NUM_TANKS-1:0]               tank_state,
    output logic [NUM_TANKS-1:0]               tank_en,
    output logic [$clog2(NUM_TANKS+1)-1:0]     alive_cnt,
    output logic [7:0]                         kill_cnt,
    output logic                               spawn_pulse
);

    localparam int CNT_W = $clog2(NUM_TANKS + 1);
    localparam int RR_W  = (NUM_TANKS > 1) ? $clog2(NUM_TANKS) : 1;

    logic [NUM_TANKS-1:0] slot_rdy, slot_occ, slot_alive_nxt, slot_en_nxt;
    logic [NUM_TANKS-1:0] slot_dead, slot_gnt;
    logic [CNT_W-1:0]     occ_cnt, alive_d, alive_q;
    logic                 gnt_vld, grant, spawn_q;
    logic [RR_W-1:0]      gnt_idx, scan_idx, rr_q, rr_d;
    logic [TICK_W-1:0]    resp_dly;
    logic [8:0]           n_dead, kill_sum;
    logic [7:0]           kill_q, kill_d;
    logic [NUM_TANKS-1:0] en_q;

    genvar g;
    for (g = 0; g < NUM_TANKS; g++) begin : g_slot
        tank_spawn_slot #(
            .INIT_DELAY (INIT_DELAY),
            .ACK_TICKS  (ACK_TICKS),
            .TICK_W     (TICK_W)
        ) u_slot (
            .clk          (clk),
            .rst          (rst),
            .tick_i       (tick),
            .game_run_i   (game_run),
            .tank_state_i (tank_state[g]),
            .grant_i      (slot_gnt[g]),
            .resp_dly_i   (resp_dly),
            .ready_o      (slot_rdy[g]),
            .occ_o        (slot_occ[g]),
            .alive_nxt_o  (slot_alive_nxt[g]),
            .en_nxt_o     (slot_en_nxt[g]),
            .death_o      (slot_dead[g])
        );
    end

`ifdef SPAWN_WAVE_EN
    // Respawn shortens by one tick per 8 kills, never below one tick.
    always_comb begin
        if (int'(kill_q[7:3]) >= RESPAWN_TICKS)
            resp_dly = TICK_W'(1);
        else
            resp_dly = TICK_W'(RESPAWN_TICKS - int'(kill_q[7:3]));
    end
`else
    assign resp_dly = TICK_W'(RESPAWN_TICKS);
`endif

    // Occupancy from registered slot states, so a death this cycle frees capacity next tick.
    always_comb begin
        occ_cnt = '0;
        for (int i = 0; i < NUM_TANKS; i++)
            occ_cnt = occ_cnt + CNT_W'(slot_occ[i]);
    end

    // First READY slot scanning upward from rr with wraparound.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_TANKS; k++) begin
            scan_idx = RR_W'((int'(rr_q) + k) % NUM_TANKS);
            if (!gnt_vld && slot_rdy[scan_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan_idx;
            end
        end
    end

    assign grant = tick && game_run && gnt_vld && (occ_cnt < CNT_W'(MAX_ALIVE));

    // One-hot grant to the chosen slot and pointer advance past it.
    always_comb begin
        for (int i = 0; i < NUM_TANKS; i++)
            slot_gnt[i] = grant && (gnt_idx == RR_W'(i));
        rr_d = grant ? RR_W'((int'(gnt_idx) + 1) % NUM_TANKS) : rr_q;
    end

    // Live count from next-state slots and saturating kill accumulation.
    always_comb begin
        alive_d = '0;
        n_dead  = '0;
        for (int i = 0; i < NUM_TANKS; i++) begin
            alive_d = alive_d + CNT_W'(slot_alive_nxt[i]);
            n_dead  = n_dead + 9'(slot_dead[i]);
        end
        kill_sum = {1'b0, kill_q} + n_dead;
        kill_d   = kill_sum[8] ? 8'hFF : kill_sum[7:0];
    end

    // Output and arbitration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q    <= '0;
            alive_q <= '0;
            kill_q  <= '0;
            spawn_q <= 1'b0;
            rr_q    <= '0;
        end else begin
            en_q    <= slot_en_nxt;
            alive_q <= alive_d;
            kill_q  <= kill_d;
            spawn_q <= grant;
            rr_q    <= rr_d;
        end
    end

    assign tank_en     = en_q;
    assign alive_cnt   = alive_q;
    assign kill_cnt    = kill_q;
    assign spawn_pulse = spawn_q;

endmodule

// File: tb/tb_tank_spawn_ctrl.sv
// Directed bench for tank_spawn_ctrl: a default instance (a) and a
// MAX_ALIVE=2 instance (b) share clock, reset, tick and game_run.
// Tank models echo tank_en one clk late; km_* masks hold a slot's tank_state
// low, kb_a kills that many freshly-alive tanks on instance a.
module tb_tank_spawn_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       game_run = 1'b1;
    logic [3:0] ts_a = '0, ts_b = '0, en_a, en_b;
    logic [3:0] km_a = '0, km_b = '0;
    logic [2:0] al_a, al_b;
    logic [7:0] kc_a, kc_b;
    logic       sp_a, sp_b;
    int         kb_a = 0;
    int         sp_cnt_a = 0;
    int         n_chk = 0, n_err = 0;
    int         n;

    always #5 clk = ~clk;

    tank_spawn_ctrl u_dut_a (
        .clk(clk), .rst(rst), .tick(tick), .game_run(game_run),
        .tank_state(ts_a), .tank_en(en_a), .alive_cnt(al_a),
        .kill_cnt(kc_a), .spawn_pulse(sp_a)
    );

    tank_spawn_ctrl #(.MAX_ALIVE(2)) u_dut_b (
        .clk(clk), .rst(rst), .tick(tick), .game_run(game_run),
        .tank_state(ts_b), .tank_en(en_b), .alive_cnt(al_b),
        .kill_cnt(kc_b), .spawn_pulse(sp_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Tank models: echo tank_en, masked by km, plus budgeted kills on a.
    task automatic upd();
        for (int i = 0; i < 4; i++) begin
            if (en_a[i] && ts_a[i] && kb_a > 0) begin
                ts_a[i] = 1'b0;
                kb_a--;
            end else begin
                ts_a[i] = en_a[i] & ~km_a[i];
            end
            ts_b[i] = en_b[i] & ~km_b[i];
        end
    endtask

    task automatic adv(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (sp_a) sp_cnt_a++;
            upd();
        end
    endtask

    task automatic tk();
        tick = 1'b1;
        adv(1);
        tick = 1'b0;
    endtask

    task automatic do_rst();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        upd();
    endtask

    // Kill slot 0 of a on a tick, then count ticks until it is granted again.
    task automatic measure(input string tag, input int exp_ticks);
        km_a[0] = 1'b1;
        upd();
        tk();
        km_a[0] = 1'b0;
        chk({tag, "_died"}, 32'(en_a[0]), 32'd0);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            adv(3);
            tk();
            n++;
            if (en_a[0]) break;
        end
        chk({tag, "_respawn_ticks"}, 32'(n), 32'(exp_ticks));
    endtask

    // Phase 1 expectations per tick (a: all default, b: MAX_ALIVE=2 with kills).
    logic [3:0] e1_en_a [16] = '{4'h0,4'h0,4'h1,4'h3,4'h7,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF};
    logic       e1_sp_a [16] = '{0,0,1,1,1,1,0,0,0,0,0,0,0,0,0,0};
    logic [2:0] e1_al_a [16] = '{0,0,1,2,3,4,4,4,4,4,4,4,4,4,4,4};
    logic [3:0] km1_b   [16] = '{4'h0,4'h0,4'h0,4'h0,4'h1,4'h0,4'h2,4'h0,4'h4,4'h0,4'h0,4'h0,4'h0,4'h8,4'h0,4'h0};
    logic [3:0] e1_en_b [16] = '{4'h0,4'h0,4'h1,4'h3,4'h2,4'h6,4'h4,4'hC,4'h8,4'h8,4'h8,4'h8,4'h8,4'h1,4'h1,4'h3};
    logic       e1_sp_b [16] = '{0,0,1,1,0,1,0,1,0,0,0,0,0,1,0,1};
    logic [7:0] e1_kc_b [16] = '{0,0,0,0,1,1,2,2,3,3,3,3,3,4,4,4};
    logic [2:0] e1_al_b [16] = '{0,0,1,2,1,2,1,2,1,1,1,1,1,1,1,2};
    // Phase 2: slot 0 of a never acknowledges.
    logic [3:0] e2_en_a [8]  = '{4'h0,4'h0,4'h1,4'h3,4'h7,4'hE,4'hE,4'hF};
    logic       e2_sp_a [8]  = '{0,0,1,1,1,1,0,1};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        do_rst();
        chk("rst_tank_en", 32'(en_a), 32'd0);
        chk("rst_alive", 32'(al_a), 32'd0);
        chk("rst_kill", 32'(kc_a), 32'd0);
        chk("rst_spawn", 32'(sp_a), 32'd0);
        sp_cnt_a = 0;

        // Phase 1: in-order spawning on a; capacity, deaths and fairness on b
        for (int t = 0; t < 16; t++) begin
            km_b = km1_b[t];
            upd();
            tk();
            km_b = '0;
            chk($sformatf("p1_en_a_t%0d", t), 32'(en_a), 32'(e1_en_a[t]));
            chk($sformatf("p1_sp_a_t%0d", t), 32'(sp_a), 32'(e1_sp_a[t]));
            chk($sformatf("p1_en_b_t%0d", t), 32'(en_b), 32'(e1_en_b[t]));
            chk($sformatf("p1_sp_b_t%0d", t), 32'(sp_b), 32'(e1_sp_b[t]));
            chk($sformatf("p1_kc_b_t%0d", t), 32'(kc_b), 32'(e1_kc_b[t]));
            adv(9);
            chk($sformatf("p1_al_a_t%0d", t), 32'(al_a), 32'(e1_al_a[t]));
            chk($sformatf("p1_al_b_t%0d", t), 32'(al_b), 32'(e1_al_b[t]));
        end
        chk("p1_spawn_count_a", 32'(sp_cnt_a), 32'd4);

        // Phase 2: acknowledge timeout and round-robin re-grant
        km_a = 4'h1;
        do_rst();
        for (int t = 0; t < 8; t++) begin
            tk();
            chk($sformatf("p2_en_a_t%0d", t), 32'(en_a), 32'(e2_en_a[t]));
            chk($sformatf("p2_sp_a_t%0d", t), 32'(sp_a), 32'(e2_sp_a[t]));
            adv(9);
        end

        // Asynchronous reset between clock edges while slot 0 sits in REQ
        chk("mid_rst_pre_en", 32'(en_a), 32'hF);
        chk("mid_rst_pre_alive", 32'(al_a), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_en", 32'(en_a), 32'd0);
        chk("mid_rst_alive", 32'(al_a), 32'd0);
        chk("mid_rst_spawn", 32'(sp_a), 32'd0);
        km_a = '0;
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        upd();
        for (int t = 0; t < 3; t++) begin
            tk();
            chk($sformatf("post_rst_en_t%0d", t), 32'(en_a), (t == 2) ? 32'h1 : 32'h0);
            adv(9);
        end

        // Phase 3: 300 deaths saturate the kill counter
        kb_a = 300;
        for (int k = 0; k < 3000 && kb_a > 0; k++) begin
            tk();
            adv(3);
        end
        chk("sat_budget_used", 32'(kb_a), 32'd0);
        repeat (20) begin
            tk();
            adv(3);
        end
        chk("sat_kill", 32'(kc_a), 32'd255);
        chk("sat_all_en", 32'(en_a), 32'hF);

        // Pause clears enables and live count, holds kills
        game_run = 1'b0;
        adv(1);
        chk("pause_en", 32'(en_a), 32'd0);
        adv(1);
        chk("pause_alive", 32'(al_a), 32'd0);
        chk("pause_kill", 32'(kc_a), 32'd255);
        tk();
        chk("pause_tick_en", 32'(en_a), 32'd0);
        game_run = 1'b1;

        // Phase 4: respawn delay at 16 and 80 kills
        do_rst();
        kb_a = 16;
        for (int k = 0; k < 500 && kb_a > 0; k++) begin
            tk();
            adv(3);
        end
        repeat (16) begin
            tk();
            adv(3);
        end
        chk("k16_kill", 32'(kc_a), 32'd16);
        chk("k16_alive", 32'(al_a), 32'd4);
`ifdef SPAWN_WAVE_EN
        measure("k16", 7);
`else
        measure("k16", 9);
`endif
        kb_a = 63;
        for (int k = 0; k < 1500 && kb_a > 0; k++) begin
            tk();
            adv(3);
        end
        repeat (16) begin
            tk();
            adv(3);
        end
        chk("k80_kill", 32'(kc_a), 32'd80);
        chk("k80_alive", 32'(al_a), 32'd4);
`ifdef SPAWN_WAVE_EN
        measure("k80", 2);
`else
        measure("k80", 9);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
